// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the EXE stage and the HI/LO multiply/divide unit.
// The pipeline side is the master; the arithmetic unit is the slave.
interface mul_div_unit_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        exe_wr;
  logic        busy;
  logic        res_valid;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  modport master (
    output req_valid, req_op, src_a, src_b, flush, exe_wr,
    input  busy, res_valid, res_hi, res_lo
  );

  modport slave (
    input  req_valid, req_op, src_a, src_b, flush, exe_wr,
    output busy, res_valid, res_hi, res_lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit producing HI/LO for the EXE stage.
// One-cycle multiply; 32-step restoring divider working on operand magnitudes.
module mul_div_unit (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;

  logic        is_signed_s;
  logic        neg_quo_s;
  logic        neg_rem_s;
  logic [31:0] b_mag_s;
  logic [63:0] prod_s;
  logic [32:0] rem_shift_s;
  logic [32:0] rem_diff_s;
  logic        quo_bit_s;
  logic [31:0] rem_next_s;
  logic [31:0] quo_next_s;

  // Datapath: product, one restoring-division step and result sign fix-up
  always_comb begin
    is_signed_s = ~op_q[0];
    b_mag_s     = (is_signed_s && b_q[31]) ? (32'd0 - b_q) : b_q;
    prod_s      = {{32{is_signed_s & a_q[31]}}, a_q} * {{32{is_signed_s & b_q[31]}}, b_q};
    rem_shift_s = {rem_q, quo_q[31]};
    rem_diff_s  = rem_shift_s - {1'b0, b_mag_s};
    if (rem_shift_s >= {1'b0, b_mag_s}) begin
      quo_bit_s  = 1'b1;
      rem_next_s = rem_diff_s[31:0];
    end else begin
      quo_bit_s  = 1'b0;
      rem_next_s = rem_shift_s[31:0];
    end
    quo_next_s = {quo_q[30:0], quo_bit_s};
    neg_quo_s  = is_signed_s & (a_q[31] ^ b_q[31]);
    neg_rem_s  = is_signed_s & a_q[31];
  end

  // Next-state and register-update logic; flush overrides everything but reset
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    res_valid_d = res_valid_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    if (bus.flush) begin
      state_d     = IDLE;
      cnt_d       = 5'd0;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            op_d  = bus.req_op;
            a_d   = bus.src_a;
            b_d   = bus.src_b;
            // quotient register starts as |dividend| and shifts left each step
            quo_d = (~bus.req_op[0] && bus.src_a[31]) ? (32'd0 - bus.src_a) : bus.src_a;
            rem_d = 32'd0;
            cnt_d = 5'd0;
            state_d = bus.req_op[1] ? DIV : MUL;
          end else begin
            state_d = IDLE;
          end
        end
        MUL: begin
          res_hi_d    = prod_s[63:32];
          res_lo_d    = prod_s[31:0];
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
        DIV: begin
          if (b_q == 32'd0) begin
            res_hi_d    = a_q;
            res_lo_d    = 32'hFFFF_FFFF;
            res_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            quo_d = quo_next_s;
            rem_d = rem_next_s;
            if (cnt_q == 5'd31) begin
              res_lo_d    = neg_quo_s ? (32'd0 - quo_next_s) : quo_next_s;
              res_hi_d    = neg_rem_s ? (32'd0 - rem_next_s) : rem_next_s;
              res_valid_d = 1'b1;
              state_d     = DONE;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
        DONE: begin
          if (bus.exe_wr) begin
            res_valid_d = 1'b0;
            state_d     = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      op_q        <= 2'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      quo_q       <= 32'd0;
      rem_q       <= 32'd0;
      res_valid_q <= 1'b0;
      res_hi_q    <= 32'd0;
      res_lo_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      res_valid_q <= res_valid_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
    end
  end

  assign bus.busy = ~rst & ~bus.flush &
                    (((state_q == IDLE) & bus.req_valid) | (state_q == MUL) | (state_q == DIV));
  assign bus.res_valid = res_valid_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.res_lo    = res_lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: latency/result model plus directed and random ops.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_div_unit_if ifc();
  mul_div_unit dut (.clk(clk), .rst(rst), .bus(ifc));

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: an operation in flight, cycles left, and the architectural HI/LO
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  int          m_left   = 0;
  logic [31:0] m_hi     = 32'd0;
  logic [31:0] m_lo     = 32'd0;
  logic [63:0] m_pend   = 64'd0;

  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin p = sa * sb; return p; end
      2'd1: return {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_done = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
    end else if (ifc.flush) begin
      m_active = 1'b0; m_done = 1'b0;
    end else if (m_done) begin
      if (ifc.exe_wr) m_done = 1'b0;
    end else if (m_active) begin
      m_left--;
      if (m_left == 0) begin
        m_active = 1'b0; m_done = 1'b1; {m_hi, m_lo} = m_pend;
      end
    end else if (ifc.req_valid) begin
      m_active = 1'b1;
      m_pend   = ref_res(ifc.req_op, ifc.src_a, ifc.src_b);
      m_left   = (!ifc.req_op[1] || ifc.src_b == 32'd0) ? 1 : 32;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(ifc.busy), 64'(!rst && !ifc.flush && (m_active || (!m_done && ifc.req_valid))));
      check("res_valid", 64'(ifc.res_valid), 64'(m_done));
      check("res_hi", 64'(ifc.res_hi), 64'(m_hi));
      check("res_lo", 64'(ifc.res_lo), 64'(m_lo));
    end
  end

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int extra, input bit use_lit, input logic [31:0] lit_hi, input logic [31:0] lit_lo);
    logic [63:0] exp;
    int n, exp_n;
    exp   = use_lit ? {lit_hi, lit_lo} : ref_res(op, a, b);
    exp_n = (!op[1] || b == 32'd0) ? 2 : 33;
    @(posedge clk); #1;
    ifc.req_valid = 1'b1; ifc.req_op = op; ifc.src_a = a; ifc.src_b = b; ifc.exe_wr = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!ifc.busy) break;
      n++;
      if (n == 2) begin
        ifc.src_a = $urandom; ifc.src_b = $urandom;
      end
    end
    check({name, "_busy_cycles"}, 64'(n), 64'(exp_n));
    check({name, "_valid"}, 64'(ifc.res_valid), 64'd1);
    check({name, "_result"}, {ifc.res_hi, ifc.res_lo}, exp);
    for (int k = 0; k < extra; k++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, 64'(ifc.res_valid), 64'd1);
      check({name, "_hold_busy"}, 64'(ifc.busy), 64'd0);
      check({name, "_hold_result"}, {ifc.res_hi, ifc.res_lo}, exp);
    end
    @(posedge clk); #1;
    ifc.exe_wr = 1'b1;
    @(posedge clk); #1;
    ifc.exe_wr = 1'b0; ifc.req_valid = 1'b0;
  endtask

  initial begin
    bit rose;
    logic [1:0]  op;
    logic [31:0] a, b;
    ifc.req_valid = 1'b0; ifc.req_op = 2'd0; ifc.src_a = 32'd0; ifc.src_b = 32'd0;
    ifc.flush = 1'b0; ifc.exe_wr = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(ifc.busy), 64'd0);
    check("reset_valid", 64'(ifc.res_valid), 64'd0);
    check("reset_hilo", {ifc.res_hi, ifc.res_lo}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Pin the reference model to hand-computed values
    check("model_mult", ref_res(2'd0, 32'hFFFF_FFFE, 32'd3), 64'hFFFF_FFFF_FFFF_FFFA);
    check("model_div_ovf", ref_res(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    check("model_div_neg", ref_res(2'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    check("model_divu0", ref_res(2'd3, 32'h1234_5678, 32'd0), 64'h1234_5678_FFFF_FFFF);

    run_op("mult_neg2x3", 2'd0, 32'hFFFF_FFFE, 32'd3, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("divu_100_7", 2'd3, 32'd100, 32'd7, 3, 1'b1, 32'd2, 32'd14);
    run_op("div_neg7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b1, 32'd0, 32'h8000_0000);
    run_op("divu_by0", 2'd3, 32'h1234_5678, 32'd0, 0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);

    // Flush at divide iteration 10
    @(posedge clk); #1;
    ifc.req_valid = 1'b1; ifc.req_op = 2'd2; ifc.src_a = 32'd1000; ifc.src_b = 32'd3;
    repeat (11) @(posedge clk);
    #1 ifc.flush = 1'b1; ifc.req_valid = 1'b0;
    @(posedge clk); #1 ifc.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(ifc.busy), 64'd0);
    rose = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ifc.res_valid) rose = 1'b1;
    end
    check("flush_no_valid", 64'(rose), 64'd0);
    run_op("multu_5x6", 2'd1, 32'd5, 32'd6, 0, 1'b1, 32'd0, 32'd30);

    // Request and flush together in IDLE must not be accepted
    @(posedge clk); #1 ifc.req_valid = 1'b1; ifc.req_op = 2'd1; ifc.flush = 1'b1;
    @(posedge clk); #1 ifc.req_valid = 1'b0; ifc.flush = 1'b0;
    repeat (3) @(negedge clk);
    check("flush_req_no_accept", 64'(ifc.res_valid), 64'd0);

    for (int t = 0; t < 40; t++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        a = $urandom_range(0, 200);
        b = $urandom_range(0, 9);
      end else begin
        a = $urandom;
        b = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      end
      run_op("rand", op, a, b, $urandom_range(0, 3), 1'b0, 32'd0, 32'd0);
    end

    // Reset at divide iteration 20
    @(posedge clk); #1;
    ifc.req_valid = 1'b1; ifc.req_op = 2'd3; ifc.src_a = 32'hDEAD_BEEF; ifc.src_b = 32'd13;
    repeat (21) @(posedge clk);
    #1 rst = 1'b1; ifc.req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 64'(ifc.busy), 64'd0);
    check("rst_mid_valid", 64'(ifc.res_valid), 64'd0);
    check("rst_mid_hilo", {ifc.res_hi, ifc.res_lo}, 64'd0);
    repeat (5) @(negedge clk);
    check("rst_idle_busy", 64'(ifc.busy), 64'd0);
    run_op("mult_after_rst", 2'd0, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 0, 1'b1, 32'd0, 32'd49);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
